// File: rtl/imem_loader.sv
// Framed byte-stream loader for the mips_16 instruction memory; holds the core in reset until a frame lands.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // state   | meaning
  // IDLE    | waiting for header 0xA5, other bytes dropped
  // COUNT   | expecting word count N
  // DATA_HI | expecting high byte of next word
  // DATA_LO | expecting low byte of next word
  // WRITE   | one-cycle memory write, input stalled
  // CHECK   | expecting trailing checksum byte
  // DONE    | frame loaded, core released
  // ERROR   | frame rejected, core held
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COUNT   = 3'd1;
  localparam logic [2:0] S_DATA_HI = 3'd2;
  localparam logic [2:0] S_DATA_LO = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK   = 3'd7;
`endif

  localparam logic [7:0] HDR   = 8'hA5;
  localparam logic [8:0] MAX_N = 9'(2 ** ADDR_W);

  logic [2:0]  state, state_nx;
  logic        accept, timed, tmo_hit, count_bad;
  logic [8:0]  n_words, wr_cnt;
  logic [7:0]  hi_byte;
  logic [31:0] tmo_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept    = in_valid & in_ready;
  assign count_bad = (in_data == 8'd0) || ({1'b0, in_data} > MAX_N);

  always_comb begin
    timed = 1'b0;
    case (state)
      S_COUNT, S_DATA_HI, S_DATA_LO: timed = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK:                       timed = 1'b1;
`endif
      default:                       timed = 1'b0;
    endcase
  end

  assign tmo_hit = (TIMEOUT != 0) && timed && !accept && (tmo_cnt == 32'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (accept && in_data == HDR) state_nx = S_COUNT;
      S_COUNT:   if (accept) state_nx = count_bad ? S_ERROR : S_DATA_HI;
      S_DATA_HI: if (accept) state_nx = S_DATA_LO;
      S_DATA_LO: if (accept) state_nx = S_WRITE;
      S_WRITE: begin
        if ((wr_cnt + 9'd1) < n_words) state_nx = S_DATA_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else                           state_nx = S_CHECK;
`else
        else                           state_nx = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK:   if (accept) state_nx = (in_data == csum) ? S_DONE : S_ERROR;
`endif
      S_DONE, S_ERROR: if (accept && in_data == HDR) state_nx = S_COUNT;
      default:   state_nx = S_IDLE;
    endcase
    if (tmo_hit) state_nx = S_ERROR;
  end

  // Status outputs are registered from the next state so they change on the deciding edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      n_words    <= '0;
      wr_cnt     <= '0;
      hi_byte    <= '0;
      tmo_cnt    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != S_WRITE);
      cpu_hold <= (state_nx != S_DONE);
      done     <= (state_nx == S_DONE);
      error    <= (state_nx == S_ERROR);
      imem_we  <= (state_nx == S_WRITE);
      tmo_cnt  <= ((TIMEOUT != 0) && timed && !accept && !tmo_hit) ? tmo_cnt + 32'd1 : 32'd0;

      case (state)
        S_COUNT: if (accept) begin
          n_words <= {1'b0, in_data};
          wr_cnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum    <= in_data;
`endif
        end
        S_DATA_HI: if (accept) begin
          hi_byte <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum    <= csum ^ in_data;
`endif
        end
        S_DATA_LO: if (accept) begin
          imem_addr  <= wr_cnt[ADDR_W-1:0];
          imem_wdata <= {hi_byte, in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum       <= csum ^ in_data;
`endif
        end
        S_WRITE: wr_cnt <= wr_cnt + 9'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames against a frame-level model.
module tb_imem_loader;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [15:0] word_q_t[$];

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_hold, done, error;

  int tests_run = 0;
  int tests_failed = 0;
  logic [19:0] wr_log[$];
  logic [19:0] exp_wr[$];

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we) wr_log.push_back({imem_addr, imem_wdata});

  // Offer one byte (called at a negedge); returns at the negedge after it was accepted, in_valid still high.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if (guard >= 20) begin
      tests_failed++;
      $display("FAIL send_byte_stall: in_ready stuck at %b, required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input byte_q_t bytes, input int max_gap);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  function automatic byte_q_t build_frame(input word_q_t words, input bit corrupt);
    byte_q_t q;
    logic [7:0] x;
    q.push_back(8'hA5);
    q.push_back(8'(words.size()));
    x = 8'(words.size());
    foreach (words[i]) begin
      q.push_back(words[i][15:8]);
      q.push_back(words[i][7:0]);
      x = x ^ words[i][15:8] ^ words[i][7:0];
    end
    if (CSUM) q.push_back(corrupt ? ~x : x);
    return q;
  endfunction

  task automatic expect_words(input word_q_t words);
    foreach (words[i]) exp_wr.push_back({4'(i), words[i]});
  endtask

  task automatic check_writes(input string name);
    tests_run++;
    if (wr_log.size() !== exp_wr.size()) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d writes, required %0d", name, wr_log.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[i]) begin
        tests_run++;
        if (wr_log[i] !== exp_wr[i]) begin
          tests_failed++;
          $display("FAIL %s_write%0d: got addr/data %h, required %h", name, i, wr_log[i], exp_wr[i]);
        end
      end
    end
    wr_log.delete();
    exp_wr.delete();
  endtask

  task automatic check_status(input string name, input bit exp_done, input bit exp_err);
    tests_run++;
    if ({done, error, cpu_hold} !== {exp_done, exp_err, !exp_done}) begin
      tests_failed++;
      $display("FAIL %s_status: got done/error/cpu_hold %b%b%b, required %b%b%b",
               name, done, error, cpu_hold, exp_done, exp_err, !exp_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(6);
    check_status("reset", 1'b0, 1'b0);
    tests_run++;
    if ({in_ready, imem_we, imem_addr, imem_wdata} !== {1'b1, 1'b0, 4'h0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready/we/addr/wdata %b %b %h %h, required 1 0 0 0000",
               in_ready, imem_we, imem_addr, imem_wdata);
    end
    check_writes("reset");
  endtask

  task automatic test_frame_ok();
    word_q_t w = '{16'h1234, 16'hABCD};
    send_frame(build_frame(w, 1'b0), 0);
    idle(2);
    expect_words(w);
    check_writes("frame_ok");
    check_status("frame_ok", 1'b1, 1'b0);
  endtask

  task automatic test_bad_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    byte_q_t f = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    word_q_t w = '{16'h1234, 16'hABCD};
    send_frame(f, 0);
    idle(2);
    expect_words(w);
    check_writes("bad_csum");
    check_status("bad_csum", 1'b0, 1'b1);
    f[6] = 8'h42;
    send_frame(f, 0);
    idle(2);
    expect_words(w);
    check_writes("resend");
    check_status("resend", 1'b1, 1'b0);
`endif
  endtask

  task automatic test_count_range();
    word_q_t w = '{16'h5A5A};
    logic [7:0] bad [2] = '{8'h00, 8'h11};
    foreach (bad[i]) begin
      send_frame(build_frame(w, 1'b0), 0);
      idle(2);
      expect_words(w);
      check_writes("cnt_pre");
      send_byte(8'hA5);
      send_byte(bad[i]);
      idle(3);
      check_status($sformatf("count_%02h", bad[i]), 1'b0, 1'b1);
      check_writes($sformatf("count_%02h", bad[i]));
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    idle(7);
    check_status("timeout_7", 1'b0, 1'b0);
    idle(1);
    check_status("timeout_8", 1'b0, 1'b1);
    idle(2);
    check_writes("timeout");
  endtask

  task automatic test_back_to_back();
    word_q_t w = '{16'h0F0F};
    send_frame(build_frame(w, 1'b0), 0);
    idle(2);
    expect_words(w);
    check_writes("bp_pre");
    send_byte(8'hA5);
    check_status("bp_header", 1'b0, 1'b0);
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'hEE);
    tests_run++;
    if ({imem_we, in_ready, imem_addr, imem_wdata} !== {1'b1, 1'b0, 4'h0, 16'hFFEE}) begin
      tests_failed++;
      $display("FAIL bp_write: got we/ready/addr/wdata %b %b %h %h, required 1 0 0 ffee",
               imem_we, in_ready, imem_addr, imem_wdata);
    end
    // The byte offered during WRITE must land in the following state.
    send_byte(CSUM ? 8'h10 : 8'hA5);
    idle(2);
    exp_wr.push_back({4'h0, 16'hFFEE});
    check_writes("bp");
    check_status("bp_held_byte", CSUM, 1'b0);
    if (CSUM) send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12);
    reset = 1'b1;
    in_data = 8'h34;
    @(negedge clk);
    tests_run++;
    if ({imem_we, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL mid_reset_we: got we/ready %b%b, required 01", imem_we, in_ready);
    end
    check_status("mid_reset", 1'b0, 1'b0);
    reset = 1'b0;
    idle(2);
    send_frame('{8'h02, 8'h34, 8'h56, 8'h78}, 0);
    idle(12);
    check_status("mid_reset_idle", 1'b0, 1'b0);
    check_writes("mid_reset");
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      word_q_t w;
      int n;
      bit corrupt, badcnt, ok;
      badcnt = ($urandom_range(0, 5) == 0);
      corrupt = CSUM && ($urandom_range(0, 3) == 0);
      if (badcnt) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
        send_byte(8'hA5);
        send_byte(8'(n));
        idle(2);
        ok = 1'b0;
      end else begin
        n = (f == 0) ? 16 : $urandom_range(1, 16);
        for (int i = 0; i < n; i++) w.push_back(16'($urandom()));
        send_frame(build_frame(w, corrupt), 2);
        idle(3);
        expect_words(w);
        ok = !corrupt;
      end
      check_writes($sformatf("rand%0d", f));
      check_status($sformatf("rand%0d", f), ok, !ok);
    end
  endtask

  initial begin
    test_reset();
    test_frame_ok();
    test_bad_checksum();
    test_count_range();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
